// File: rtl/control_seleccion_frecuencia_pkg.sv
// control_seleccion_frecuencia_pkg
// Shared definitions for the button sequencer in front of the frequency
// selector: FSM state encoding, step direction codes and selector width.
package control_seleccion_frecuencia_pkg;

    // Width of the selector code f.
    localparam int SEL_W = 6;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STEP    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_REPEAT  = 3'd3,
        ST_LOCK    = 3'd4,
        ST_RELEASE = 3'd5
    } estado_t;

    // Step request codes on botones.
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_DOWN = 2'b01;
    localparam logic [1:0] DIR_NONE = 2'b00;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/control_seleccion_frecuencia_if.sv
// control_seleccion_frecuencia_if
// Link between the sequencer and the frequency selector.
//   ENf      : selector enable, one-cycle step pulse
//   botones  : step direction (DIR_UP / DIR_DOWN / DIR_NONE)
//   f_actual : current selector code fed back to the sequencer
// master = sequencer side, slave = selector side.
interface control_seleccion_frecuencia_if;
    import control_seleccion_frecuencia_pkg::*;

    logic             ENf;
    logic [1:0]       botones;
    logic [SEL_W-1:0] f_actual;

    modport master (output ENf, output botones, input f_actual);
    modport slave  (input ENf, input botones, output f_actual);
endinterface

// File: rtl/control_seleccion_frecuencia_antirrebote.sv
// antirrebote
// Two-flop synchronizer followed by a debounce counter for one raw button.
//   clk   : system clock
//   rst   : synchronous, active-high reset
//   din   : raw asynchronous, bouncing button input
//   level : debounced level; flips only after DEBOUNCE_CYCLES consecutive
//           synchronised samples that differ from it
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            // Any sample agreeing with the current level restarts the count.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_seleccion_frecuencia.sv
// control_seleccion_frecuencia
// Debounces the up/down buttons, arbitrates between them and issues
// single-cycle step requests to the frequency selector, with hold-to-repeat.
// Steps that would take the selector past 0 or F_MAX are suppressed.
//   clk      : system clock
//   rst      : synchronous, active-high reset
//   en       : mode enable; 0 forces IDLE with outputs 0
//   btn_up   : raw increment button
//   btn_down : raw decrement button
//   sel      : selector link (ENf, botones out; f_actual in)
//   ocupado  : high while a press is being handled (state != IDLE)
module control_seleccion_frecuencia
    import control_seleccion_frecuencia_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               HOLD_CYCLES     = 50000000,
    parameter int               REPEAT_CYCLES   = 10000000,
    parameter logic [SEL_W-1:0] F_MAX           = 6'd63
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           btn_up,
    input  logic                           btn_down,
    control_seleccion_frecuencia_if.master sel,
    output logic                           ocupado
);

    localparam int TW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);

    logic          lvl_up, lvl_down;
    estado_t       state, state_next;
    logic [1:0]    dir, dir_next;
    logic [TW-1:0] timer, timer_next;
    logic          enf_next;
    logic [1:0]    bot_next;
    logic          latched, other, step_ok;

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_up (
        .clk(clk), .rst(rst), .din(btn_up), .level(lvl_up)
    );
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_down (
        .clk(clk), .rst(rst), .din(btn_down), .level(lvl_down)
    );

    // Button that started the press and the opposing one.
    assign latched = (dir == DIR_UP) ? lvl_up   : lvl_down;
    assign other   = (dir == DIR_UP) ? lvl_down : lvl_up;
    // A step is only requested if the selector can still move that way.
    assign step_ok = (dir == DIR_UP) ? (sel.f_actual != F_MAX)
                                     : (sel.f_actual != '0);

    always_comb begin
        state_next = state;
        dir_next   = dir;
        timer_next = timer;
        enf_next   = 1'b0;
        bot_next   = DIR_NONE;
        if (!en) begin
            state_next = ST_IDLE;
            timer_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timer_next = '0;
                    if (lvl_up && lvl_down) begin
                        state_next = ST_LOCK;
                    end else if (lvl_up) begin
                        state_next = ST_STEP;
                        dir_next   = DIR_UP;
                    end else if (lvl_down) begin
                        state_next = ST_STEP;
                        dir_next   = DIR_DOWN;
                    end
                end
                ST_STEP: begin
                    if (step_ok) begin
                        enf_next = 1'b1;
                        bot_next = dir;
                    end
                    state_next = ST_HOLD;
                    timer_next = '0;
                end
                ST_HOLD: begin
                    if (other) begin
                        state_next = ST_LOCK;
                        timer_next = '0;
                    end else if (!latched) begin
                        state_next = ST_RELEASE;
                        timer_next = '0;
                    end else if (timer == TW'(HOLD_CYCLES - 1)) begin
                        state_next = ST_REPEAT;
                        timer_next = '0;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (other) begin
                        state_next = ST_LOCK;
                        timer_next = '0;
                    end else if (!latched) begin
                        state_next = ST_RELEASE;
                        timer_next = '0;
                    end else if (timer == TW'(REPEAT_CYCLES - 1)) begin
                        // Timer restarts on every repeat so it never wraps.
                        if (step_ok) begin
                            enf_next = 1'b1;
                            bot_next = dir;
                        end
                        timer_next = '0;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
                ST_LOCK: begin
                    timer_next = '0;
                    if (!lvl_up && !lvl_down) state_next = ST_IDLE;
                end
                ST_RELEASE: begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end
                default: begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Outputs are registered: a pulse decided in STEP/REPEAT shows up on the
    // following cycle; ocupado follows the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            dir         <= DIR_NONE;
            timer       <= '0;
            sel.ENf     <= 1'b0;
            sel.botones <= DIR_NONE;
            ocupado     <= 1'b0;
        end else begin
            state       <= state_next;
            dir         <= dir_next;
            timer       <= timer_next;
            sel.ENf     <= enf_next;
            sel.botones <= bot_next;
            ocupado     <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_control_seleccion_frecuencia.sv
// tb_control_seleccion_frecuencia
// Directed bench with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
// Pulses are logged with the posedge index they appeared on; press offsets
// are measured from the posedge that first samples the new input level.
module tb_control_seleccion_frecuencia;

    logic clk = 1'b0;
    logic rst, en, btn_up, btn_down;
    logic ocupado;

    control_seleccion_frecuencia_if sel_if();

    control_seleccion_frecuencia #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (3),
        .F_MAX          (6'd63)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .sel     (sel_if),
        .ocupado (ocupado)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] bot;
    } pulse_t;

    typedef struct {
        logic       up;
        logic       dn;
        logic [5:0] f;
        int         n;        // raw press length in cycles
        int         exp_cnt;  // expected number of step pulses
        logic [1:0] exp_bot;  // expected step code
        int         exp_ocu;  // expected cycles with ocupado high
    } vec_t;

    pulse_t pq[$];
    int     cyc = 0;
    int     ocu_cnt = 0;
    int     viol = 0;
    int     n_cmp = 0;
    int     n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sel_if.ENf || sel_if.botones != 2'b00) begin
            pulse_t p;
            p.cyc = cyc;
            p.bot = sel_if.botones;
            pq.push_back(p);
        end
        if (ocupado) ocu_cnt++;
        if (sel_if.botones == 2'b11 || sel_if.ENf != (sel_if.botones != 2'b00)) viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offset from press sample edge to the i-th pulse of a held press.
    function automatic int exp_off(input int i);
        return (i == 0) ? 7 : 20 + 3 * (i - 1);
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int s;
        int m;
        pq.delete();
        ocu_cnt = 0;
        sel_if.f_actual = v.f;
        s = cyc + 1;
        btn_up = v.up;
        btn_down = v.dn;
        repeat (v.n) tick();
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (25) tick();
        check($sformatf("vec%0d_count", idx), pq.size(), v.exp_cnt);
        m = (pq.size() < v.exp_cnt) ? pq.size() : v.exp_cnt;
        for (int i = 0; i < m; i++) begin
            check($sformatf("vec%0d_pulse%0d_offset", idx, i), pq[i].cyc - s, exp_off(i));
            check($sformatf("vec%0d_pulse%0d_code", idx, i), int'(pq[i].bot), int'(v.exp_bot));
        end
        check($sformatf("vec%0d_ocupado_cycles", idx), ocu_cnt, v.exp_ocu);
    endtask

    vec_t vecs[9];

    initial begin
        int s;
        vecs[0] = '{1'b1, 1'b0, 6'd5,  8,  1,  2'b10, 9};
        vecs[1] = '{1'b0, 1'b1, 6'd5,  8,  1,  2'b01, 9};
        vecs[2] = '{1'b1, 1'b0, 6'd5,  40, 10, 2'b10, 41};
        vecs[3] = '{1'b0, 1'b1, 6'd0,  20, 0,  2'b01, 21};
        vecs[4] = '{1'b1, 1'b0, 6'd63, 20, 0,  2'b10, 21};
        vecs[5] = '{1'b1, 1'b0, 6'd0,  8,  1,  2'b10, 9};
        vecs[6] = '{1'b0, 1'b1, 6'd63, 20, 3,  2'b01, 21};
        vecs[7] = '{1'b1, 1'b0, 6'd62, 17, 2,  2'b10, 18};
        vecs[8] = '{1'b1, 1'b1, 6'd5,  10, 0,  2'b00, 10};

        // Reset with buttons low, then a quiet window.
        rst = 1'b1; en = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        sel_if.f_actual = 6'd5;
        repeat (5) tick();
        check("reset_ENf", int'(sel_if.ENf), 0);
        check("reset_botones", int'(sel_if.botones), 0);
        check("reset_ocupado", int'(ocupado), 0);
        rst = 1'b0;
        pq.delete();
        ocu_cnt = 0;
        repeat (50) tick();
        check("post_reset_pulses", pq.size(), 0);
        check("post_reset_ocupado", ocu_cnt, 0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Bouncing down button, then a stable press.
        pq.delete();
        sel_if.f_actual = 6'd5;
        for (int i = 0; i < 3; i++) begin
            btn_down = 1'b1; tick(); tick();
            btn_down = 1'b0; tick(); tick();
        end
        s = cyc + 1;
        btn_down = 1'b1;
        repeat (10) tick();
        btn_down = 1'b0;
        repeat (25) tick();
        check("bounce_count", pq.size(), 1);
        if (pq.size() > 0) begin
            check("bounce_offset", pq[0].cyc - s, 7);
            check("bounce_code", int'(pq[0].bot), 1);
        end

        // Conflict: down rises while up is in HOLD.
        pq.delete();
        s = cyc + 1;
        btn_up = 1'b1;
        repeat (10) tick();
        btn_down = 1'b1;
        repeat (30) tick();
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (20) tick();
        check("conflict_count", pq.size(), 1);
        if (pq.size() > 0) check("conflict_offset", pq[0].cyc - s, 7);
        check("conflict_idle_ocupado", int'(ocupado), 0);
        s = cyc + 1;
        btn_up = 1'b1;
        repeat (8) tick();
        btn_up = 1'b0;
        repeat (25) tick();
        check("conflict_repress_count", pq.size(), 2);
        if (pq.size() > 1) check("conflict_repress_offset", pq[1].cyc - s, 7);

        // en low blocks everything; rising en with the button held is a press.
        pq.delete();
        ocu_cnt = 0;
        en = 1'b0;
        btn_up = 1'b1;
        repeat (20) tick();
        check("en_low_pulses", pq.size(), 0);
        check("en_low_ocupado", ocu_cnt, 0);
        s = cyc + 1;
        en = 1'b1;
        repeat (5) tick();
        btn_up = 1'b0;
        repeat (25) tick();
        check("en_rise_count", pq.size(), 1);
        if (pq.size() > 0) check("en_rise_offset", pq[0].cyc - s, 1);

        // Reset mid-press with the button still held.
        btn_up = 1'b1;
        repeat (12) tick();
        rst = 1'b1;
        tick(); tick();
        check("midreset_ocupado", int'(ocupado), 0);
        check("midreset_botones", int'(sel_if.botones), 0);
        pq.delete();
        s = cyc + 1;
        rst = 1'b0;
        repeat (10) tick();
        btn_up = 1'b0;
        repeat (25) tick();
        check("midreset_count", pq.size(), 1);
        if (pq.size() > 0) check("midreset_offset", pq[0].cyc - s, 7);

        check("pulse_shape_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
